// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   XLEN             : default data/address width
//   RESET_PC_DEFAULT : default PC loaded on reset (word aligned)
//   INSTR_NOP        : encoding shown on the decode port after reset (addi x0,x0,0)
//   fetch_state_e    : fetch FSM state encoding
package instr_fetch_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch stage and its neighbours.
//   imem request  : imem_req_valid/imem_req_ready/imem_req_addr (fetch -> memory)
//   imem response : imem_rsp_valid/imem_rsp_data                 (memory -> fetch)
//   redirect      : redirect_valid/redirect_pc                   (branch unit -> fetch)
//   decode        : instr/instr_pc/instr_valid/instr_ready       (fetch -> decode)
// master = fetch stage, slave = environment (memory, branch unit, decode).
interface instr_fetch_if #(
  parameter int unsigned XLEN = 32
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Owns the PC, issues one word fetch at a time to instruction memory, waits for
// the (variable latency) response and holds it for decode until accepted.
// Redirects replace the PC and squash any wrong-path word, including one whose
// request has already been accepted by memory (tracked by r_drop).
// Ports:
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : instr_fetch_if.master (imem request/response, redirect, decode)
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = instr_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);

  fetch_state_e    r_state;
  fetch_state_e    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_inflight;
  logic            r_drop;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_instr_pc;
  logic            r_instr_valid;
  logic [XLEN-1:0] w_redirect_target;
  logic            w_req_fire;
  logic            w_rsp_fire;

  // Low two bits of the redirect target are forced to zero.
  assign w_redirect_target = bus.redirect_pc & ~XLEN'(3);
  assign w_req_fire        = (r_state == S_REQ)  && bus.imem_req_ready;
  // Responses outside S_WAIT are protocol errors and never observed.
  assign w_rsp_fire        = (r_state == S_WAIT) && bus.imem_rsp_valid;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a redirect overrides every other event.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_REQ: begin
        if (bus.imem_req_ready) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          if (bus.imem_rsp_valid) w_state_next = S_REQ;
        end else if (bus.imem_rsp_valid) begin
          w_state_next = r_drop ? S_REQ : S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid || bus.instr_ready) w_state_next = S_REQ;
      end
      default: w_state_next = S_REQ;
    endcase
  end

  // Output decode: request channel is combinational from state and PC.
  always_comb begin
    bus.imem_req_valid = (r_state == S_REQ);
    bus.imem_req_addr  = r_pc;
  end

  // Datapath: PC, in-flight PC, drop flag and registered decode outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_pc_inflight <= RESET_PC;
      r_drop        <= 1'b0;
      r_instr       <= XLEN'(INSTR_NOP);
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_pc          <= w_redirect_target;
      r_instr_valid <= 1'b0;
      // An old-PC request accepted this cycle, or one still outstanding,
      // must have its response squashed; a response arriving now is
      // discarded directly and clears the obligation.
      if (w_req_fire) begin
        r_drop <= 1'b1;
      end else if (r_state == S_WAIT) begin
        r_drop <= !bus.imem_rsp_valid;
      end
    end else begin
      if (w_req_fire) begin
        r_pc_inflight <= r_pc;
        r_pc          <= r_pc + XLEN'(4);
      end
      if (w_rsp_fire) begin
        if (r_drop) begin
          r_drop <= 1'b0;
        end else begin
          r_instr       <= bus.imem_rsp_data;
          r_instr_pc    <= r_pc_inflight;
          r_instr_valid <= 1'b1;
        end
      end
      if ((r_state == S_HOLD) && bus.instr_ready) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;

endmodule
